piso_serializer: RTL and testbench

- Downstream stage of the 8-bit parallel register: captures the register's q0..q7 word and shifts it out one bit per clock on a single serial line.
- Valid/ready handshake on the parallel side, with a serial valid line and stall input on the output side.
- Raises a one-cycle done pulse after the last bit so the register/controller can present the next word.

---
 rtl/piso_serializer.sv | 92 +++++++++
 tb/tb_piso_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a WIDTH-bit word over a valid/ready handshake,
// streams it out one bit per accepted cycle and then raises a one-cycle done pulse.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             sout_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state, state_next;
    logic [WIDTH-1:0] sreg, sreg_next;
    logic [CW-1:0]    cnt, cnt_next;

    // State, shift register and bit counter update; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            sreg  <= sreg_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and state-decoded outputs; the counter holds the bits left after the current one.
    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        cnt_next   = cnt;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;

        case (state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_next = S_SHIFT;
                    sreg_next  = d;
                    cnt_next   = CW'(WIDTH - 1);
                end
            end

            S_SHIFT: begin
                sout_valid = 1'b1;
                busy       = 1'b1;
                sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
                if (sout_ready) begin
                    if (cnt != '0) begin
                        sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                              : {1'b0, sreg[WIDTH-1:1]};
                        cnt_next  = cnt - CW'(1);
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done       = 1'b1;
                busy       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an MSB-first and an LSB-first instance share
// the same stimulus and are checked against fixed frame vectors and a frame-level model.
module tb_piso_serializer;

    typedef struct {
        logic [7:0] d;
        logic [7:0] msb_bits;
        logic [7:0] lsb_bits;
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       load_valid;
    logic       sout_ready;

    logic lr_m, so_m, sv_m, dn_m, bz_m;
    logic lr_l, so_l, sv_l, dn_l, bz_l;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .d(d), .load_valid(load_valid), .load_ready(lr_m),
        .sout_ready(sout_ready), .sout(so_m), .sout_valid(sv_m), .done(dn_m), .busy(bz_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .d(d), .load_valid(load_valid), .load_ready(lr_l),
        .sout_ready(sout_ready), .sout(so_l), .sout_valid(sv_l), .done(dn_l), .busy(bz_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Output vectors are {load_ready, sout, sout_valid, done, busy}.
    task automatic checkAll(input string tag, input logic [4:0] exp_m, input logic [4:0] exp_l);
        checkOutput({tag, " msb"}, {3'b0, lr_m, so_m, sv_m, dn_m, bz_m}, {3'b0, exp_m});
        checkOutput({tag, " lsb"}, {3'b0, lr_l, so_l, sv_l, dn_l, bz_l}, {3'b0, exp_l});
    endtask

    task automatic checkIdle(input string tag);
        checkAll({tag, " idle"}, 5'b10000, 5'b10000);
    endtask

    task automatic checkDone(input string tag);
        checkAll({tag, " done"}, 5'b00011, 5'b00011);
    endtask

    task automatic checkBit(input string tag, input logic bm, input logic bl);
        checkAll({tag, " bit"}, {1'b0, bm, 3'b101}, {1'b0, bl, 3'b101});
    endtask

    // One complete frame with the consumer always ready.
    task automatic applyStimulus(input string tag, input frame_vec_t v);
        d          = v.d;
        load_valid = 1'b1;
        sout_ready = 1'b1;
        step();
        load_valid = 1'b0;
        d          = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            checkBit(tag, v.msb_bits[7-i], v.lsb_bits[7-i]);
            step();
        end
        checkDone(tag);
        step();
        checkIdle(tag);
    endtask

    initial begin
        frame_vec_t vecs[5];
        int         mode;
        int         idx;
        logic [7:0] word;
        logic       in_rst_n, in_lv, in_sr;
        logic [7:0] in_d;

        vecs[0] = '{d: 8'hD6, msb_bits: 8'b11010110, lsb_bits: 8'b01101011};
        vecs[1] = '{d: 8'h9C, msb_bits: 8'b10011100, lsb_bits: 8'b00111001};
        vecs[2] = '{d: 8'hFF, msb_bits: 8'b11111111, lsb_bits: 8'b11111111};
        vecs[3] = '{d: 8'h00, msb_bits: 8'b00000000, lsb_bits: 8'b00000000};
        vecs[4] = '{d: 8'hA5, msb_bits: 8'b10100101, lsb_bits: 8'b10100101};

        // Reset held for two edges while a word is offered: reset must win.
        rst_n      = 1'b0;
        load_valid = 1'b1;
        d          = 8'hD6;
        sout_ready = 1'b1;
        step();
        step();
        checkIdle("reset");
        rst_n      = 1'b1;
        load_valid = 1'b0;
        step();
        checkIdle("after reset");

        for (int k = 0; k < 5; k++)
            applyStimulus($sformatf("frame%0d", k), vecs[k]);

        // Back-to-back with load_valid held: the second word waits for the idle cycle.
        d          = 8'hD6;
        load_valid = 1'b1;
        step();
        d = 8'h9C;
        for (int i = 0; i < 8; i++) begin
            checkBit("b2b first", vecs[0].msb_bits[7-i], vecs[0].lsb_bits[7-i]);
            step();
        end
        checkDone("b2b first");
        step();
        checkIdle("b2b gap");
        step();
        for (int i = 0; i < 8; i++) begin
            checkBit("b2b second", vecs[1].msb_bits[7-i], vecs[1].lsb_bits[7-i]);
            step();
        end
        checkDone("b2b second");
        load_valid = 1'b0;
        step();
        checkIdle("b2b end");

        // Backpressure: three stalled cycles after the second bit.
        d          = 8'h9C;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkBit("stall", vecs[1].msb_bits[7-i], vecs[1].lsb_bits[7-i]);
            if (i == 1) begin
                sout_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    checkBit("stall hold", vecs[1].msb_bits[6], vecs[1].lsb_bits[6]);
                end
                sout_ready = 1'b1;
            end
            step();
        end
        checkDone("stall");
        step();
        checkIdle("stall end");

        // Reset after the fourth bit: frame abandoned, no done pulse, next word still works.
        d          = 8'hD6;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkBit("abort", vecs[0].msb_bits[7-i], vecs[0].lsb_bits[7-i]);
            if (i < 3)
                step();
        end
        rst_n = 1'b0;
        step();
        checkIdle("abort reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checkIdle("abort quiet");
        end
        applyStimulus("abort next", vecs[2]);

        // Randomized traffic against a frame-level model: which bit of which word is on the line.
        mode = 0;
        idx  = 0;
        word = '0;
        for (int c = 0; c < 800; c++) begin
            in_rst_n   = ($urandom_range(0, 49) != 0);
            in_lv      = 1'($urandom_range(0, 1));
            in_sr      = ($urandom_range(0, 3) != 0);
            in_d       = 8'($urandom);
            rst_n      = in_rst_n;
            load_valid = in_lv;
            sout_ready = in_sr;
            d          = in_d;
            step();
            if (!in_rst_n) begin
                mode = 0;
                idx  = 0;
            end else if (mode == 0) begin
                if (in_lv) begin
                    word = in_d;
                    idx  = 0;
                    mode = 1;
                end
            end else if (mode == 1) begin
                if (in_sr) begin
                    if (idx == 7)
                        mode = 2;
                    else
                        idx = idx + 1;
                end
            end else begin
                mode = 0;
            end
            checkAll("random",
                     {mode == 0, (mode == 1) ? word[7-idx] : 1'b0, mode == 1, mode == 2, mode != 0},
                     {mode == 0, (mode == 1) ? word[idx]   : 1'b0, mode == 1, mode == 2, mode != 0});
        end

        rst_n      = 1'b1;
        load_valid = 1'b0;
        sout_ready = 1'b1;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
